// File: rtl/adc_peak_meter.sv
// adc_peak_meter: windowed peak |x| and overload count of the raw ADC stream
module adc_peak_meter #(
  parameter int WIDTH = 16,
  parameter logic [6:0] BASE = 7'hA,
  parameter int DEF_LOG2 = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_stb,
  input  logic [6:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_ovf,
  output logic [WIDTH-1:0] peak_o,
  output logic [15:0]      ovf_cnt_o,
  output logic             valid_o,
  output logic             clip_o
);
  localparam logic [WIDTH-1:0] MAXP = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [4:0] DEF = 5'(DEF_LOG2);
  logic cfg_wr, en, o1, v1, o2, v2, term;
  logic [4:0] lg, lg_n;
  logic [WIDTH-1:0] d1, a1, a2, run_max, mx;
  logic [15:0] run_cnt, oc;
  logic [23:0] cnt, ones;
  logic unused;
  assign unused = ^{set_data[31:9], set_data[7:5]};
  assign cfg_wr = set_stb && set_addr == BASE;
  assign lg_n = set_data[4:0] < 5'd4 ? 5'd4 : set_data[4:0] > 5'd24 ? 5'd24 : set_data[4:0];
  assign a1 = d1 == MINV ? MAXP : d1[WIDTH-1] ? -d1 : d1;
  assign ones = (24'd1 << lg) - 24'd1;
  assign term = en && v2 && cnt == ones;
  assign mx = a2 > run_max ? a2 : run_max;
  assign oc = run_cnt == 16'hFFFF ? run_cnt : run_cnt + 16'(o2);
  // config register: clamped window exponent and enable
  always_ff @(posedge clk)
    if (rst) begin
      lg <= DEF;
      en <= 1'b1;
    end else if (cfg_wr) begin
      lg <= lg_n;
      en <= set_data[8];
    end
  // S1 sample capture and S2 saturating abs; a write discards in-flight samples
  always_ff @(posedge clk)
    if (rst) begin
      d1 <= '0;
      o1 <= 1'b0;
      v1 <= 1'b0;
      a2 <= '0;
      o2 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      d1 <= in_data;
      o1 <= in_ovf;
      v1 <= en && !cfg_wr;
      a2 <= a1;
      o2 <= o1;
      v2 <= v1 && en && !cfg_wr;
    end
  // S3 window accumulation and publish on terminal count
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      run_max <= '0;
      run_cnt <= '0;
      peak_o <= '0;
      ovf_cnt_o <= '0;
      valid_o <= 1'b0;
      clip_o <= 1'b0;
    end else begin
      valid_o <= term && !cfg_wr;
      if (cfg_wr || !en) begin
        cnt <= '0;
        run_max <= '0;
        run_cnt <= '0;
      end else if (v2) begin
        cnt <= term ? '0 : cnt + 24'd1;
        run_max <= term ? '0 : mx;
        run_cnt <= term ? '0 : oc;
      end
      if (term && !cfg_wr) begin
        peak_o <= mx;
        ovf_cnt_o <= oc;
        clip_o <= mx == MAXP || oc != 16'd0;
      end
    end
endmodule

// File: tb/tb_adc_peak_meter.sv
// tb_adc_peak_meter: table-driven window vectors plus reconfigure/reset/disable sequences
module tb_adc_peak_meter;
  localparam logic [6:0] BASE = 7'hA;
  logic clk, rst, set_stb, in_ovf, valid_o, clip_o;
  logic [6:0] set_addr;
  logic [31:0] set_data;
  logic [15:0] in_data, peak_o, ovf_cnt_o;
  int cyc = 0, checks = 0, fails = 0;
  typedef struct {
    int lg;
    bit ramp;
    logic [15:0] sv;
    int sp;
    logic [31:0] omask;
    bit oall;
    bit jw;
    logic [15:0] e_peak;
    logic [15:0] e_cnt;
    bit e_clip;
  } win_t;
  typedef struct {
    int c;
    logic [15:0] p;
    logic [15:0] n;
    logic k;
  } exp_t;
  win_t tbl[11];
  exp_t q[$];

  adc_peak_meter #(.WIDTH(16), .BASE(BASE), .DEF_LOG2(16)) dut (
    .clk(clk), .rst(rst), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .in_data(in_data), .in_ovf(in_ovf), .peak_o(peak_o), .ovf_cnt_o(ovf_cnt_o),
    .valid_o(valid_o), .clip_o(clip_o)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (!rst) begin
      if (valid_o) begin
        checks++;
        if (q.size() != 0 && q[0].c == cyc) begin
          if (peak_o !== q[0].p || ovf_cnt_o !== q[0].n || clip_o !== q[0].k) begin
            fails++;
            $display("FAIL pulse@%0d got peak=%h cnt=%h clip=%b need peak=%h cnt=%h clip=%b",
                     cyc, peak_o, ovf_cnt_o, clip_o, q[0].p, q[0].n, q[0].k);
          end
          void'(q.pop_front());
        end else begin
          fails++;
          $display("FAIL unexpected_pulse@%0d got valid_o=1 need 0", cyc);
        end
      end else if (q.size() != 0 && q[0].c == cyc) begin
        checks++;
        fails++;
        $display("FAIL missing_pulse@%0d got valid_o=0 need 1", cyc);
        void'(q.pop_front());
      end
    end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] need);
    checks++;
    if (got !== need) begin
      fails++;
      $display("FAIL %s got=%h need=%h", nm, got, need);
    end
  endtask

  task automatic step(input logic [15:0] d, input logic o);
    in_data = d;
    in_ovf = o;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int l, input bit e);
    set_stb = 1;
    set_addr = BASE;
    set_data = 32'(l) | (e ? 32'h100 : 32'h0);
    step(16'h0, 1'b0);
    set_stb = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) step(16'h0, 1'b0);
  endtask

  task automatic run_win(input win_t w);
    int n;
    logic [15:0] d;
    logic o;
    exp_t e;
    n = 1 << w.lg;
    for (int i = 0; i < n; i++) begin
      d = w.ramp ? 16'(i % 16) : (i == w.sp ? w.sv : 16'h0);
      o = w.oall || (i < 32 ? w.omask[i[4:0]] : 1'b0);
      if (w.jw && i == 7) begin
        set_stb = 1;
        set_addr = BASE + 7'd1;
        set_data = 32'h105;
      end
      if (i == n - 1) begin
        e.c = cyc + 3;
        e.p = w.e_peak;
        e.n = w.e_cnt;
        e.k = w.e_clip;
        q.push_back(e);
      end
      step(d, o);
      set_stb = 0;
    end
  endtask

  initial begin
    tbl[0]  = '{4, 1, 16'h0, -1, 32'h0, 0, 0, 16'h000F, 16'h0, 0};
    tbl[1]  = '{4, 1, 16'h0, -1, 32'h0, 0, 1, 16'h000F, 16'h0, 0};
    tbl[2]  = '{4, 0, 16'h8000, 5, 32'h0, 0, 0, 16'h7FFF, 16'h0, 1};
    tbl[3]  = '{4, 0, 16'h0, -1, 32'h0, 0, 0, 16'h0000, 16'h0, 0};
    tbl[4]  = '{4, 0, 16'hFFFF, 15, 32'h0, 0, 0, 16'h0001, 16'h0, 0};
    tbl[5]  = '{4, 0, 16'h7FFF, 0, 32'h0, 0, 0, 16'h7FFF, 16'h0, 1};
    tbl[6]  = '{4, 0, 16'hFF00, 8, 32'h0, 0, 0, 16'h0100, 16'h0, 0};
    tbl[7]  = '{5, 0, 16'h1234, 20, 32'h800010F1, 0, 0, 16'h1234, 16'h7, 1};
    tbl[8]  = '{5, 0, 16'h0, -1, 32'h0, 0, 0, 16'h0000, 16'h0, 0};
    tbl[9]  = '{16, 0, 16'h0, -1, 32'h0, 1, 0, 16'h0000, 16'hFFFF, 1};
    tbl[10] = '{4, 0, 16'h0042, 9, 32'h4, 0, 0, 16'h0042, 16'h1, 1};
    rst = 1;
    set_stb = 0;
    set_addr = 0;
    set_data = 0;
    in_data = 0;
    in_ovf = 0;
    repeat (3) step(16'h0, 1'b0);
    chk("reset_peak", 32'(peak_o), 32'h0);
    chk("reset_cnt", 32'(ovf_cnt_o), 32'h0);
    chk("reset_valid", 32'(valid_o), 32'h0);
    chk("reset_clip", 32'(clip_o), 32'h0);
    rst = 0;
    for (int k = 0; k < 9; k++) begin
      if (k == 0 || tbl[k].lg != tbl[k-1].lg) begin
        if (k != 0) drain();
        cfg(tbl[k].lg, 1);
      end
      run_win(tbl[k]);
    end
    drain();
    cfg(4, 1);
    repeat (10) step(16'h0500, 1'b0);
    cfg(2, 1);
    run_win(tbl[0]);
    repeat (16) step(16'h0300, 1'b0);
    step(16'h0, 1'b0);
    cfg(4, 1);
    run_win(tbl[6]);
    repeat (5) step(16'h0700, 1'b1);
    rst = 1;
    step(16'h0, 1'b0);
    rst = 0;
    chk("rst_peak", 32'(peak_o), 32'h0);
    chk("rst_cnt", 32'(ovf_cnt_o), 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_clip", 32'(clip_o), 32'h0);
    repeat (20) step(16'h0700, 1'b1);
    cfg(4, 1);
    run_win(tbl[10]);
    drain();
    cfg(4, 0);
    repeat (40) step(16'h7FFF, 1'b1);
    chk("dis_peak", 32'(peak_o), 32'h42);
    chk("dis_cnt", 32'(ovf_cnt_o), 32'h1);
    chk("dis_clip", 32'(clip_o), 32'h1);
    cfg(4, 1);
    run_win(tbl[0]);
    drain();
    cfg(16, 1);
    run_win(tbl[9]);
    drain();
    chk("pending_pulses", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
